// File: rtl/uart_tx_buf.sv
// Buffered UART transmitter: a valid/ready byte FIFO feeding an 8-bit serialiser.
// Frames are start, D0..D7 LSB first, optional even parity, then 1 or 2 stop bits.
module uart_tx_buf #(
  parameter int BAUD_DIV  = 5208,
  parameter int DEPTH     = 16,
  parameter int PARITY_EN = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                     sclk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  output logic                     in_ready,
  output logic                     tx,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_cnt
);

  localparam int AW  = $clog2(DEPTH);
  localparam int AW1 = AW + 1;
  localparam int CW  = $clog2(BAUD_DIV);

  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [AW:0]   FULL_CNT  = AW1'(DEPTH);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   cnt_q;
  logic          push;
  logic          pop;
  logic          fifo_nonempty;

  // Ready looks only at the registered count, so a full FIFO never accepts
  // a byte on the same edge that it pops one.
  assign in_ready      = (cnt_q != FULL_CNT);
  assign push          = in_valid & in_ready;
  assign fifo_nonempty = (cnt_q != '0);
  assign fifo_cnt      = cnt_q;

  // NOTE: storage is not reset; pointers and count define which entries are valid.
  always_ff @(posedge sclk) begin
    if (push) begin
      mem[wr_ptr_q] <= in_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge sclk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Serialiser FSM
  // ---------------------------------------------------------------------------
  state_t        state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic          stop_q, stop_d;
  logic [7:0]    byte_q, byte_d;
  logic          tx_q, tx_d;
  logic          baud_end;

  assign baud_end = (baud_q == BAUD_LAST);

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    byte_d  = byte_q;
    pop     = 1'b0;

    if (state_q != S_IDLE) begin
      baud_d = baud_end ? '0 : baud_q + 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (fifo_nonempty) begin
          pop     = 1'b1;
          byte_d  = mem[rd_ptr_q];
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_end) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (baud_end) begin
          if (bit_q == 3'd7) begin
            state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
            stop_d  = 1'b0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (baud_end) begin
          state_d = S_STOP;
          stop_d  = 1'b0;
        end
      end
      S_STOP: begin
        if (baud_end) begin
          if (stop_q == STOP_LAST) begin
            // Chain straight into the next start bit when a byte is waiting.
            if (fifo_nonempty) begin
              pop     = 1'b1;
              byte_d  = mem[rd_ptr_q];
              state_d = S_START;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            stop_d = stop_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The line level is a function of the next state so tx comes straight from a flop.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      S_IDLE:   tx_d = 1'b1;
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = byte_d[bit_d];
      S_PARITY: tx_d = ^byte_d;
      S_STOP:   tx_d = 1'b1;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      byte_q  <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      byte_q  <= byte_d;
      tx_q    <= tx_d;
    end
  end

  assign tx   = tx_q;
  assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_buf.sv
// Self-checking bench for uart_tx_buf: exact-timing frame tables plus a serial
// decoder that pops a byte scoreboard for every frame seen on tx.
module tb_uart_tx_buf;

  localparam int BAUD_DIV = 4;
  localparam int DEPTH    = 4;
  localparam int CNT_W    = $clog2(DEPTH) + 1;

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;  // [0]=start, [8:1]=D7..D0 reversed onto the line, [9]=stop
  } vec_t;

  logic             sclk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [7:0]       in_data;
  logic             in_ready;
  logic             tx;
  logic             busy;
  logic [CNT_W-1:0] fifo_cnt;

  logic             p_valid;
  logic [7:0]       p_data;
  logic             p_ready;
  logic             p_tx;
  logic             p_busy;
  logic [CNT_W-1:0] p_cnt;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] exp_q[$];
  bit         mon_en = 1'b1;

  always #5 sclk = ~sclk;

  uart_tx_buf #(.BAUD_DIV(BAUD_DIV), .DEPTH(DEPTH), .PARITY_EN(0), .STOP_BITS(1)) dut (
    .sclk(sclk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .tx(tx), .busy(busy), .fifo_cnt(fifo_cnt)
  );

  uart_tx_buf #(.BAUD_DIV(BAUD_DIV), .DEPTH(DEPTH), .PARITY_EN(1), .STOP_BITS(2)) dut_p (
    .sclk(sclk), .rst(rst), .in_valid(p_valid), .in_data(p_data),
    .in_ready(p_ready), .tx(p_tx), .busy(p_busy), .fifo_cnt(p_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge sclk);
    #1;
  endtask

  // Hold a byte until the DUT takes it; the accepted byte joins the scoreboard.
  task automatic push(input logic [7:0] b);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_data  = b;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge sclk);
      done = in_ready;
      @(posedge sclk);
    end
    #1;
    in_valid = 1'b0;
    check("push_accept", done, 1);
    if (done) exp_q.push_back(b);
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int n = 0; n < 3000 && !done; n++) begin
      tick(1);
      done = (exp_q.size() == 0) && (busy === 1'b0) && (fifo_cnt === '0);
    end
    check("drain", done, 1);
  endtask

  // Serial decoder: find the falling edge of a start bit, sample mid-bit.
  initial begin : monitor
    logic       prev_tx;
    logic [7:0] got;
    prev_tx = 1'b1;
    forever begin
      tick(1);
      if (mon_en && prev_tx === 1'b1 && tx === 1'b0) begin
        tick(2);
        check("mon_start_bit", tx, 0);
        for (int i = 0; i < 8; i++) begin
          tick(4);
          got[i] = tx;
        end
        tick(4);
        check("mon_stop_bit", tx, 1);
        check("mon_frame_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("mon_byte", got, exp_q.pop_front());
      end
      prev_tx = tx;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin : stim
    vec_t        vecs[4];
    logic [11:0] pframe;
    int          busy_cycles;
    int          viol;

    vecs[0] = '{8'hA5, 10'b1101001010};
    vecs[1] = '{8'h3C, 10'b1001111000};
    vecs[2] = '{8'h00, 10'b1000000000};
    vecs[3] = '{8'hFF, 10'b1111111110};
    pframe  = 12'b111000001110;  // 0x07: start, 1110_0000, parity 1, two stops

    rst = 1'b1; in_valid = 1'b0; in_data = '0; p_valid = 1'b0; p_data = '0;
    tick(3);
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_cnt", fifo_cnt, 0);
    check("rst_ready", in_ready, 1);
    check("rst_p_tx", p_tx, 1);
    rst = 1'b0;
    tick(2);

    // Single frames with exact per-bit timing.
    foreach (vecs[v]) begin
      wait_drain();
      push(vecs[v].data);
      check("latency_tx_idle", tx, 1);
      check("latency_cnt", fifo_cnt, 1);
      tick(1);
      check("pop_cnt", fifo_cnt, 0);
      for (int j = 0; j < 10; j++) begin
        check($sformatf("frame%0d_bit%0d", v, j), tx, vecs[v].frame[j]);
        if (j < 9) tick(4);
      end
      tick(3);
      check("busy_last_cycle", busy, 1);
      tick(1);
      check("busy_end", busy, 0);
      check("tx_idle_after", tx, 1);
    end

    // Back-to-back bytes: busy must stay high across three frames.
    wait_drain();
    push(8'h01); push(8'h02); push(8'h03);
    check("b2b_busy", busy, 1);
    busy_cycles = 2;  // start edge and the following edge have already elapsed
    for (int n = 0; n < 300; n++) begin
      tick(1);
      if (busy) busy_cycles++;
      else break;
    end
    check("b2b_busy_span", busy_cycles, 120);

    // Overfill: ready drops at DEPTH, the held byte goes in after a pop.
    wait_drain();
    push(8'h10);
    tick(1);
    check("ovf_cnt_after_pop", fifo_cnt, 0);
    for (int i = 0; i < 4; i++) push(8'h11 + 8'(i));
    check("ovf_ready_low", in_ready, 0);
    check("ovf_cnt_full", fifo_cnt, 4);
    push(8'h15);
    check("ovf_cnt_refill", fifo_cnt, 4);
    wait_drain();

    // Push and pop on the same edge with two bytes queued.
    in_valid = 1'b1; in_data = 8'h81; tick(1);
    in_data = 8'h42; tick(1);
    in_data = 8'h24; tick(1);
    in_valid = 1'b0;
    exp_q.push_back(8'h81); exp_q.push_back(8'h42); exp_q.push_back(8'h24);
    check("pp_cnt_setup", fifo_cnt, 2);
    tick(38);
    check("pp_cnt_before", fifo_cnt, 2);
    check("pp_busy_before", busy, 1);
    in_valid = 1'b1; in_data = 8'h18; tick(1);
    in_valid = 1'b0;
    exp_q.push_back(8'h18);
    check("pp_cnt_after", fifo_cnt, 2);
    check("pp_next_start", tx, 0);
    wait_drain();

    // Parity + two stop bits on the second instance.
    check("p_ready", p_ready, 1);
    p_valid = 1'b1; p_data = 8'h07; tick(1);
    p_valid = 1'b0;
    tick(1);
    for (int j = 0; j < 12; j++) begin
      check($sformatf("pframe_bit%0d", j), p_tx, pframe[j]);
      if (j < 11) tick(4);
    end
    tick(3);
    check("p_busy_last", p_busy, 1);
    tick(1);
    check("p_busy_end", p_busy, 0);
    check("p_cnt_end", p_cnt, 0);

    // Reset during D3 with two bytes queued: everything is discarded.
    mon_en = 1'b0;
    in_valid = 1'b1; in_data = 8'h5A; tick(1);
    in_data = 8'hC3; tick(1);
    in_data = 8'h3C; tick(1);
    in_valid = 1'b0;
    tick(15);
    check("mid_busy", busy, 1);
    check("mid_cnt", fifo_cnt, 2);
    rst = 1'b1; tick(1);
    rst = 1'b0;
    check("abort_tx", tx, 1);
    check("abort_busy", busy, 0);
    check("abort_cnt", fifo_cnt, 0);
    check("abort_ready", in_ready, 1);
    viol = 0;
    for (int n = 0; n < 100; n++) begin
      tick(1);
      if (tx !== 1'b1 || busy !== 1'b0) viol++;
    end
    check("abort_quiet", viol, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
